// File: rtl/fir_readout_sequencer.sv
// Readout engine for the RNS FIR result register file: waits for done, walks
// every channel/word, streams each word on valid/ready and keeps a running checksum.
module fir_readout_sequencer #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int          DEPTH          = 16,
  parameter int          NUM_CH         = 1,
  parameter int          CH_STRIDE      = 16,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     done,
  output logic [ADDR_W-1:0]        regAddr,
  input  logic [DATA_W-1:0]        regData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(NUM_CH):0]  out_ch,
  output logic [$clog2(DEPTH):0]   out_idx,
  output logic [DATA_W-1:0]        checksum,
  output logic                     busy,
  output logic                     finished,
  output logic                     timeout
);
  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int IDX_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_CAPTURE, S_PUSH, S_FINISH, S_TIMEOUT
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  ch;
  logic [IDX_W-1:0] idx;
  logic [31:0]      wait_cnt;
  logic             last_idx, last_ch;

  assign last_idx = (idx == IDX_W'(DEPTH - 1));
  assign last_ch  = (ch == CH_W'(NUM_CH - 1));

  function automatic logic [ADDR_W-1:0] addr_of(input logic [CH_W-1:0] c,
                                                input logic [IDX_W-1:0] i);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(c) * ADDR_W'(CH_STRIDE) + ADDR_W'(i);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      regAddr   <= ADDR_W'(BASE_ADDR);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_idx   <= '0;
      checksum  <= '0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      timeout   <= 1'b0;
      ch        <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_FINISH, S_TIMEOUT: begin
          if (start) begin
            state    <= S_WAIT;
            finished <= 1'b0;
            timeout  <= 1'b0;
            checksum <= '0;
            ch       <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          // done wins over a watchdog expiry landing on the same cycle
          if (done) begin
            state   <= S_READ;
            regAddr <= addr_of(ch, idx);
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == 32'(TIMEOUT_CYCLES)) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_READ: state <= S_CAPTURE;
        S_CAPTURE: begin
          out_data  <= regData;
          out_ch    <= ch;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= S_PUSH;
        end
        S_PUSH: begin
          if (out_ready) begin
            checksum  <= checksum + out_data;
            out_valid <= 1'b0;
            if (!last_idx) begin
              idx     <= idx + 1'b1;
              regAddr <= addr_of(ch, idx + 1'b1);
              state   <= S_READ;
            end else if (!last_ch) begin
              idx     <= '0;
              ch      <= ch + 1'b1;
              regAddr <= addr_of(ch + 1'b1, '0);
              state   <= S_READ;
            end else begin
              state    <= S_FINISH;
              finished <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
